// File: rtl/if_priv_ctrl.sv
// if_priv_ctrl -- instruction-fetch privileged-op controller.
//
// Watches pre-decoded fetch groups for IBAR, CSR and TLB ops. When one is
// found it stalls and flushes the fetch path, waits for the op to reach EX,
// then waits for the side effect to settle. For IBAR this means both caches
// idle for IDLE_CYCLES consecutive cycles. For CSR/TLB it means the done
// strobe. Finally it issues a one-cycle redirect to the instruction after the op.
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   flush                          backend flush, overrides everything
//   dec_valid, dec_pc              fetch group valid / PC of slot 0
//   ibar_flag, csr_flag, tlb_flag  per-slot op flags (bit0 = slot0)
//   ex_ibar, ex_csr, ex_tlb        held op reached EX
//   icache_idle, dcache_idle       caches have nothing outstanding
//   csr_done, tlb_done             CSR write / TLB op finished
//   fetch_stall                    block IF1 FIFO (any non-IDLE state)
//   flush_fetch                    discard younger groups (WAIT_EX_* only)
//   set_pc, pc_target              redirect pulse and its target
//   state                          current FSM encoding
//   stall_cnt                      saturating count of non-IDLE cycles
module if_priv_ctrl #(
   parameter int IDLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        flush,
   input  logic        dec_valid,
   input  logic [31:0] dec_pc,
   input  logic [1:0]  ibar_flag,
   input  logic [1:0]  csr_flag,
   input  logic [1:0]  tlb_flag,
   input  logic        ex_ibar,
   input  logic        ex_csr,
   input  logic        ex_tlb,
   input  logic        icache_idle,
   input  logic        dcache_idle,
   input  logic        csr_done,
   input  logic        tlb_done,
   output logic        fetch_stall,
   output logic        flush_fetch,
   output logic        set_pc,
   output logic [31:0] pc_target,
   output logic [2:0]  state,
   output logic [15:0] stall_cnt
);

   typedef enum logic [2:0] {
      IDLE            = 3'b000,
      WAIT_EX_IBAR    = 3'b001,
      WAIT_EX_CSR     = 3'b010,
      WAIT_CACHE_IDLE = 3'b011,
      WAIT_CSR_OK     = 3'b100,
      WAIT_TLB_OK     = 3'b101,
      REDIRECT        = 3'b110,
      WAIT_EX_TLB     = 3'b111
   } state_t;

   // The counter only has to reach IDLE_CYCLES-1. It leaves the state at
   // that value, so it never wraps.
   localparam int            CW        = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
   localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] idle_cnt_q, idle_cnt_d;
   logic [31:0]   pc_target_q;
   logic [15:0]   stall_cnt_q;

   logic          both_idle;
   logic          detect;
   logic          win_bit0;

   assign both_idle = icache_idle && dcache_idle;

   // A detection only counts from IDLE, and only when no flush is present.
   // When a flush arrives together with a detection, the flush wins.
   assign detect = (state_q == IDLE) && dec_valid && !flush &&
                   ((|ibar_flag) || (|csr_flag) || (|tlb_flag));

   // Choose the slot of the winning op, checking ibar, then csr, then tlb.
   // Slot 0 redirects to +4 and slot 1 to +8.
   always_comb begin
      win_bit0 = tlb_flag[0];
      if (|ibar_flag)     win_bit0 = ibar_flag[0];
      else if (|csr_flag) win_bit0 = csr_flag[0];
   end

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = '0;
      unique case (state_q)
         IDLE: begin
            if (dec_valid) begin
               if (|ibar_flag)     state_d = WAIT_EX_IBAR;
               else if (|csr_flag) state_d = WAIT_EX_CSR;
               else if (|tlb_flag) state_d = WAIT_EX_TLB;
            end
         end
         WAIT_EX_IBAR: if (ex_ibar) state_d = WAIT_CACHE_IDLE;
         WAIT_EX_CSR:  if (ex_csr)  state_d = WAIT_CSR_OK;
         WAIT_EX_TLB:  if (ex_tlb)  state_d = WAIT_TLB_OK;
         WAIT_CACHE_IDLE: begin
            if (both_idle) begin
               if (idle_cnt_q == IDLE_LAST) state_d = REDIRECT;
               else                         idle_cnt_d = idle_cnt_q + CW'(1);
            end
         end
         WAIT_CSR_OK: if (csr_done) state_d = REDIRECT;
         WAIT_TLB_OK: if (tlb_done) state_d = REDIRECT;
         REDIRECT:    state_d = IDLE;
         default:     state_d = IDLE;
      endcase
      if (flush) begin
         state_d    = IDLE;
         idle_cnt_d = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments, so every flop samples the values from before the edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         idle_cnt_q  <= '0;
         pc_target_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         idle_cnt_q <= idle_cnt_d;
         if (detect)
            pc_target_q <= dec_pc + (win_bit0 ? 32'd4 : 32'd8);
         // Flush does not clear this counter. It keeps a running total.
         if (state_q != IDLE && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   // Moore outputs, decoded only from the current state. A flush during
   // REDIRECT therefore still lets that cycle's set_pc through.
   always_comb begin
      fetch_stall = (state_q != IDLE);
      flush_fetch = (state_q == WAIT_EX_IBAR) || (state_q == WAIT_EX_CSR) ||
                    (state_q == WAIT_EX_TLB);
      set_pc      = (state_q == REDIRECT);
   end

   assign pc_target = pc_target_q;
   assign state     = state_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/if_priv_ctrl.md
IF_PRIV_CTRL -- requirements
Module: if_priv_ctrl

Interface
REQ-001 Parameter IDLE_CYCLES, default 2: consecutive cycles both caches must report idle before an IBAR redirect.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  backend flush; highest priority.
REQ-005 dec_valid  input  1  pre-decoded fetch group valid.
REQ-006 dec_pc  input  32  PC of slot 0 of the fetch group.
REQ-007 ibar_flag, csr_flag, tlb_flag  input  2 each  bit0 = slot0 is that op, bit1 = slot1 is that op.
REQ-008 ex_ibar, ex_csr, ex_tlb  input  1 each  the held privileged op reached EX.
REQ-009 icache_idle, dcache_idle  input  1 each  cache has no outstanding operation.
REQ-010 csr_done, tlb_done  input  1 each  CSR write / TLB op completed.
REQ-011 fetch_stall  output  1  blocks the IF1 FIFO from accepting new groups.
REQ-012 flush_fetch  output  1  discards younger fetched groups.
REQ-013 set_pc  output  1  one-cycle redirect pulse.
REQ-014 pc_target  output  32  redirect PC; valid while set_pc=1.
REQ-015 state  output  3  current FSM state encoding.
REQ-016 stall_cnt  output  16  saturating count of non-IDLE cycles.

Function
REQ-017 States and encodings: IDLE=000, WAIT_EX_IBAR=001, WAIT_EX_CSR=010, WAIT_CACHE_IDLE=011, WAIT_CSR_OK=100, WAIT_TLB_OK=101, REDIRECT=110, WAIT_EX_TLB=111.
REQ-018 In IDLE with dec_valid=1, the block SHALL check flags in priority order ibar > csr > tlb and go to WAIT_EX_IBAR, WAIT_EX_CSR or WAIT_EX_TLB on the next edge; all flags zero or dec_valid=0 -> stay IDLE.
REQ-019 On detection, pc_target SHALL latch dec_pc+4 if bit0 of the winning flag is set, else dec_pc+8; the add is mod 2^32.
REQ-020 pc_target SHALL hold its value until the next detection.
REQ-021 WAIT_EX_IBAR -> WAIT_CACHE_IDLE when ex_ibar=1.
REQ-022 WAIT_EX_CSR -> WAIT_CSR_OK when ex_csr=1.
REQ-023 WAIT_EX_TLB -> WAIT_TLB_OK when ex_tlb=1.
REQ-024 In all three WAIT_EX_* states the FSM SHALL otherwise hold.
REQ-025 In WAIT_CACHE_IDLE, idle_cnt SHALL increment on each cycle with icache_idle&&dcache_idle and clear to 0 otherwise.
REQ-026 WAIT_CACHE_IDLE -> REDIRECT on the cycle both caches are idle and idle_cnt==IDLE_CYCLES-1.
REQ-027 idle_cnt SHALL be 0 on entry to WAIT_CACHE_IDLE.
REQ-028 WAIT_CSR_OK -> REDIRECT when csr_done=1; WAIT_TLB_OK -> REDIRECT when tlb_done=1.
REQ-029 REDIRECT SHALL last exactly one cycle, then -> IDLE; a new detection is evaluated only from IDLE.
REQ-030 Outputs are Moore: fetch_stall=1 in every non-IDLE state; flush_fetch=1 only in WAIT_EX_*; set_pc=1 only in REDIRECT.
REQ-031 flush=1 in any state SHALL force IDLE and clear idle_cnt on the next edge, and SHALL override any simultaneous ex_*, done or detection event.
REQ-032 A flush that arrives while in REDIRECT SHALL NOT suppress that cycle's set_pc, because set_pc is decoded from the current state.
REQ-033 stall_cnt SHALL increment on each edge where state!=IDLE, saturate at 0xFFFF, and is not cleared by flush.

Reset
REQ-034 rstn=0 SHALL asynchronously force state=IDLE, idle_cnt=0, pc_target=0 and stall_cnt=0.
REQ-035 During reset fetch_stall, flush_fetch and set_pc SHALL be 0.
REQ-036 Reset asserted mid-sequence SHALL abandon the sequence with no set_pc pulse.

Verification
REQ-037 IBAR redirect: dec_pc=0x1C000010, ibar_flag=01 -> WAIT_EX_IBAR with flush_fetch=1; ex_ibar pulse -> WAIT_CACHE_IDLE; caches idle 2 cycles -> set_pc=1 with pc_target=0x1C000014.
REQ-038 Priority: csr_flag=10 and tlb_flag=01 together, dec_pc=0x100 -> WAIT_EX_CSR; after ex_csr then csr_done -> pc_target=0x108.
REQ-039 Idle debounce: in WAIT_CACHE_IDLE drive idle pattern 1,0,1,1 -> REDIRECT only after the final 1.
REQ-040 Flush mid-sequence: flush in WAIT_TLB_OK with tlb_done=1 in the same cycle -> IDLE next cycle, no set_pc.
REQ-041 Wrap and saturation: dec_pc=0xFFFFFFFC with tlb_flag=10 -> pc_target=0x00000004; hold WAIT_EX_TLB for 70000 cycles -> stall_cnt=0xFFFF.
REQ-042 Async reset: assert rstn=0 mid-clock in WAIT_CSR_OK -> state=000 and fetch_stall=0 immediately, with no set_pc pulse afterward.
